// File: rtl/note_judge_pkg.sv
// Shared types and constants for the note judge: game state encoding,
// the saturating BCD score ceiling and the lane bit positions.
package note_judge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_e;

   localparam logic [15:0] BCD_MAX = 16'h9999;

   localparam int LANE1 = 1;
   localparam int LANE2 = 0;

endpackage

// File: rtl/btn_sync_edge.sv
// Per-lane button conditioner: SYNC_STAGES-deep synchroniser followed by a
// registered rising-edge detect, so a held button yields a single pulse.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic btn_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   // Synchroniser chain, previous-level flop and registered rise pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= {SYNC_STAGES{1'b0}};
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/note_judge.sv
// Note judge: judges each scrolled note as hit/miss/wrong and keeps BCD score,
// combo, lives and the IDLE/PLAY/OVER state. Optional macro: COMBO_BONUS_EN.
module note_judge
   import note_judge_pkg::*;
#(
   parameter int LIVES_INIT   = 3,
   parameter int SYNC_STAGES  = 2,
   parameter int COMBO_W      = 8,
   parameter int BONUS_THRESH = 8
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               scroll,
   input  logic [1:0]         lane_bot,
   input  logic [1:0]         btn,
   input  logic               start,
   output logic [15:0]        score,
   output logic [COMBO_W-1:0] combo,
   output logic [1:0]         lives,
   output logic [1:0]         hit,
   output logic [1:0]         miss,
   output logic [1:0]         wrong,
   output logic               game_over
);

   state_e             state_q, state_d;
   logic [15:0]        score_q, score_d;
   logic [COMBO_W-1:0] combo_q, combo_d, combo_base_s;
   logic [1:0]         lives_q, lives_d, armed_q, armed_d;
   logic [1:0]         hit_q, hit_d, miss_q, miss_d, wrong_q, wrong_d;
   logic               scroll_d_q;
   logic [1:0]         rise_s, eff_s, hit_s, miss_s, wrong_s;
   logic [1:0]         hit_cnt_s, miss_cnt_s, lives_dec_s;
   logic               bonus_s;
   logic [2:0]         add_s;
   logic [COMBO_W:0]   combo_sum_s;

   // Digit-serial BCD add of a small increment; any carry out of digit 3 pins at 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [2:0] inc);
      logic [15:0] r;
      logic [4:0]  d;
      logic [2:0]  c;
      r = 16'h0000;
      c = inc;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[i*4 +: 4]} + {2'b00, c};
         if (d > 5'd9) begin
            r[i*4 +: 4] = 4'(d - 5'd10);
            c = 3'd1;
         end else begin
            r[i*4 +: 4] = d[3:0];
            c = 3'd0;
         end
      end
      return (c != 3'd0) ? BCD_MAX : r;
   endfunction

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l1 (
      .clk(clk), .n_rst(n_rst), .btn_i(btn[LANE1]), .rise_o(rise_s[LANE1])
   );
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l2 (
      .clk(clk), .n_rst(n_rst), .btn_i(btn[LANE2]), .rise_o(rise_s[LANE2])
   );

   // In the scroll_d cycle the freshly loaded row is already judgeable.
   assign eff_s   = scroll_d_q ? lane_bot : armed_q;
   assign hit_s   = rise_s & eff_s;
   assign wrong_s = rise_s & ~eff_s;
   assign miss_s  = {2{scroll_d_q}} & armed_q;

   assign hit_cnt_s   = {1'b0, hit_s[LANE1]} + {1'b0, hit_s[LANE2]};
   assign miss_cnt_s  = {1'b0, miss_s[LANE1]} + {1'b0, miss_s[LANE2]};
   assign lives_dec_s = (lives_q > miss_cnt_s) ? (lives_q - miss_cnt_s) : 2'd0;

   // Any miss or wrong clears the combo before this cycle's hits are added.
   assign combo_base_s = ((|miss_s) || (|wrong_s)) ? {COMBO_W{1'b0}} : combo_q;
   assign combo_sum_s  = {1'b0, combo_base_s} + {{(COMBO_W-1){1'b0}}, hit_cnt_s};
`ifdef COMBO_BONUS_EN
   assign bonus_s = (combo_base_s >= COMBO_W'(BONUS_THRESH));
`else
   assign bonus_s = 1'b0;
`endif
   assign add_s = {1'b0, hit_cnt_s} << bonus_s;

   // Next-state and judgment logic; start reloads the game from any state.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      combo_d = combo_q;
      lives_d = lives_q;
      armed_d = armed_q;
      hit_d   = 2'b00;
      miss_d  = 2'b00;
      wrong_d = 2'b00;
      if (start) begin
         state_d = PLAY;
         score_d = 16'h0000;
         combo_d = {COMBO_W{1'b0}};
         lives_d = 2'(LIVES_INIT);
         armed_d = 2'b00;
      end else begin
         case (state_q)
            PLAY: begin
               hit_d   = hit_s;
               miss_d  = miss_s;
               wrong_d = wrong_s;
               armed_d = eff_s & ~hit_s;
               score_d = bcd_add_sat(score_q, add_s);
               combo_d = combo_sum_s[COMBO_W] ? {COMBO_W{1'b1}} : combo_sum_s[COMBO_W-1:0];
               lives_d = lives_dec_s;
               state_d = (lives_dec_s == 2'd0) ? OVER : PLAY;
            end
            IDLE, OVER: state_d = state_q;
            default:    state_d = IDLE;
         endcase
      end
   end

   // State, datapath and registered judgment outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         score_q    <= 16'h0000;
         combo_q    <= {COMBO_W{1'b0}};
         lives_q    <= 2'd0;
         armed_q    <= 2'b00;
         hit_q      <= 2'b00;
         miss_q     <= 2'b00;
         wrong_q    <= 2'b00;
         scroll_d_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         combo_q    <= combo_d;
         lives_q    <= lives_d;
         armed_q    <= armed_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         wrong_q    <= wrong_d;
         scroll_d_q <= scroll;
      end
   end

   assign score     = score_q;
   assign combo     = combo_q;
   assign lives     = lives_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign wrong     = wrong_q;
   assign game_over = (state_q == OVER);

endmodule
